// File: rtl/command_executor.sv
// Terminal command executor: queues decoded escape-sequence commands, tracks the cursor
// and a circular scroll offset, and drives the text-RAM write port used by the renderer.
package command_executor_pkg;
  typedef enum logic [3:0] {INPUT, IND, NEL, RI, CUU, CUD, CUF, CUB, CUP} CommandsType;

  typedef struct packed {
    logic [7:0] Pchar;
    logic [7:0] Pn1;
    logic [7:0] Pn2;
  } Param_t;

  typedef struct packed {
    CommandsType ctype;
    Param_t      prm;
  } cmd_t;
endpackage

module command_executor
  import command_executor_pkg::*;
#(
  parameter int ROWS       = 24,
  parameter int COLS       = 80,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commandReady,
  input  CommandsType commandType,
  input  Param_t      param,
  output logic        ram_we,
  output logic [4:0]  ram_row,
  output logic [6:0]  ram_col,
  output logic [7:0]  ram_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic [4:0]  top_line,
  output logic        busy,
  output logic        overflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [8:0]  LAST_ROW9 = 9'(ROWS - 1);
  localparam logic [8:0]  LAST_COL9 = 9'(COLS - 1);
  localparam logic [5:0]  ROWS6     = 6'(ROWS);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, WRITE} state_t;

  state_t      state;
  cmd_t        cmd;
  logic        wrap_pending;
  logic        deferred;

  cmd_t        fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push;
  logic [AW-1:0] head_idx;

  function automatic logic [4:0] phys(input logic [4:0] top, input logic [4:0] row);
    logic [5:0] s;
    s = {1'b0, top} + {1'b0, row};
    if (s >= ROWS6) s = s - ROWS6;
    return s[4:0];
  endfunction

  function automatic logic printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  assign head_idx = rd_ptr[AW-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = (state == IDLE) && !empty;
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign push     = commandReady && (!full || pop);
  assign busy     = (state != IDLE);

  // NOTE: storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_t'{ctype: commandType, prm: param};
  end

  // Printable-character write decided at pop time so the RAM port is registered.
  logic       pop_we;
  logic [4:0] pop_row;
  logic [6:0] pop_col;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop_we  = 1'b0;
    pop_row = phys(top_line, cursor_row);
    pop_col = cursor_col;
    if (fifo_mem[head_idx].ctype == INPUT && printable(fifo_mem[head_idx].prm.Pchar)) begin
      if (!wrap_pending) begin
        pop_we = 1'b1;
      end else if (cursor_row != LAST_ROW) begin
        pop_we  = 1'b1;
        pop_row = phys(top_line, cursor_row + 5'd1);
        pop_col = '0;
      end
    end
  end

  logic [4:0] n_row, n_top, clr_row;
  logic [6:0] n_col;
  logic       n_wrap, n_defer, scroll, do_ind, do_ri;
  logic [8:0] pn1, pn2, row9, col9, t_a, t_b;

  always_comb begin
    n_row   = cursor_row;
    n_col   = cursor_col;
    n_top   = top_line;
    n_wrap  = 1'b0;
    n_defer = 1'b0;
    scroll  = 1'b0;
    clr_row = top_line;
    do_ind  = 1'b0;
    do_ri   = 1'b0;
    pn1     = (cmd.prm.Pn1 == 8'd0) ? 9'd1 : {1'b0, cmd.prm.Pn1};
    pn2     = (cmd.prm.Pn2 == 8'd0) ? 9'd1 : {1'b0, cmd.prm.Pn2};
    row9    = {4'b0, cursor_row};
    col9    = {2'b0, cursor_col};
    t_a     = '0;
    t_b     = '0;
    case (cmd.ctype)
      INPUT: begin
        if (printable(cmd.prm.Pchar)) begin
          if (wrap_pending) begin
            do_ind  = 1'b1;
            n_defer = (cursor_row == LAST_ROW);
            n_col   = n_defer ? 7'd0 : 7'd1;
          end else if (cursor_col == LAST_COL) begin
            n_wrap = 1'b1;
          end else begin
            n_col = cursor_col + 7'd1;
          end
        end else begin
          case (cmd.prm.Pchar)
            8'h0D:   n_col = '0;
            8'h0A:   do_ind = 1'b1;
            8'h08:   n_col = (cursor_col == 7'd0) ? 7'd0 : cursor_col - 7'd1;
            default: ;
          endcase
        end
      end
      IND: do_ind = 1'b1;
      NEL: begin
        n_col  = '0;
        do_ind = 1'b1;
      end
      RI:  do_ri = 1'b1;
      CUU: begin
        t_a   = row9 - pn1;
        n_row = (pn1 >= row9) ? 5'd0 : t_a[4:0];
      end
      CUD: begin
        t_a   = row9 + pn1;
        n_row = (t_a > LAST_ROW9) ? LAST_ROW : t_a[4:0];
      end
      CUF: begin
        t_a   = col9 + pn1;
        n_col = (t_a > LAST_COL9) ? LAST_COL : t_a[6:0];
      end
      CUB: begin
        t_a   = col9 - pn1;
        n_col = (pn1 >= col9) ? 7'd0 : t_a[6:0];
      end
      CUP: begin
        t_a   = pn1 - 9'd1;
        t_b   = pn2 - 9'd1;
        n_row = (t_a > LAST_ROW9) ? LAST_ROW : t_a[4:0];
        n_col = (t_b > LAST_COL9) ? LAST_COL : t_b[6:0];
      end
      default: ;
    endcase

    if (do_ind) begin
      if (cursor_row != LAST_ROW) begin
        n_row = cursor_row + 5'd1;
      end else begin
        scroll  = 1'b1;
        n_top   = (top_line == LAST_ROW) ? 5'd0 : top_line + 5'd1;
        clr_row = top_line;
      end
    end
    if (do_ri) begin
      if (cursor_row != 5'd0) begin
        n_row = cursor_row - 5'd1;
      end else begin
        scroll  = 1'b1;
        n_top   = (top_line == 5'd0) ? LAST_ROW : top_line - 5'd1;
        clr_row = n_top;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wrap_pending <= 1'b0;
      deferred     <= 1'b0;
      overflow     <= 1'b0;
      ram_we       <= 1'b0;
      ram_row      <= '0;
      ram_col      <= '0;
      ram_data     <= '0;
      cursor_row   <= '0;
      cursor_col   <= '0;
      top_line     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (commandReady && full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (pop) begin
            cmd      <= fifo_mem[head_idx];
            state    <= EXEC;
            ram_we   <= pop_we;
            ram_row  <= pop_row;
            ram_col  <= pop_col;
            ram_data <= fifo_mem[head_idx].prm.Pchar;
          end
        end
        EXEC: begin
          cursor_row   <= n_row;
          cursor_col   <= n_col;
          top_line     <= n_top;
          wrap_pending <= n_wrap;
          deferred     <= n_defer;
          if (scroll) begin
            state    <= CLEAR;
            ram_we   <= 1'b1;
            ram_row  <= clr_row;
            ram_col  <= '0;
            ram_data <= 8'h20;
          end else begin
            state  <= IDLE;
            ram_we <= 1'b0;
          end
        end
        CLEAR: begin
          if (ram_col == LAST_COL) begin
            // The deferred char lands on the freshly cleared row, which is the new bottom line.
            if (deferred) begin
              state    <= WRITE;
              ram_col  <= '0;
              ram_data <= cmd.prm.Pchar;
            end else begin
              state  <= IDLE;
              ram_we <= 1'b0;
            end
          end else begin
            ram_col <= ram_col + 7'd1;
          end
        end
        WRITE: begin
          ram_we     <= 1'b0;
          cursor_col <= 7'd1;
          deferred   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_executor.sv
// Self-checking bench for command_executor: expected RAM writes go into a scoreboard queue
// at stimulus time and are popped by a monitor whenever ram_we is seen high.
module tb_command_executor;
  import command_executor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commandReady = 1'b0;
  CommandsType commandType = INPUT;
  Param_t      param = '0;
  logic        ram_we;
  logic [4:0]  ram_row;
  logic [6:0]  ram_col;
  logic [7:0]  ram_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [4:0]  top_line;
  logic        busy;
  logic        overflow;

  int total  = 0;
  int passed = 0;
  bit sb_en  = 1'b1;

  typedef struct {
    logic [4:0] row;
    logic [6:0] col;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  command_executor #(.ROWS(24), .COLS(80), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .commandReady(commandReady), .commandType(commandType),
    .param(param), .ram_we(ram_we), .ram_row(ram_row), .ram_col(ram_col),
    .ram_data(ram_data), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .top_line(top_line), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    wr_t e;
    if (rst && sb_en && ram_we) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got row %0d col %0d data %02h, required no write",
                 ram_row, ram_col, ram_data);
      end else begin
        e = exp_q.pop_front();
        if (ram_row !== e.row || ram_col !== e.col || ram_data !== e.data)
          $display("FAIL ram_write: got row %0d col %0d data %02h, required row %0d col %0d data %02h",
                   ram_row, ram_col, ram_data, e.row, e.col, e.data);
        else passed++;
      end
    end
  end

  task automatic expect_write(input logic [4:0] r, input logic [6:0] c, input logic [7:0] d);
    exp_q.push_back('{row: r, col: c, data: d});
  endtask

  // Called at a negedge; holds the strobe for exactly one rising edge.
  task automatic put(input CommandsType t, input logic [7:0] c, input logic [7:0] n1,
                     input logic [7:0] n2);
    commandType  = t;
    param        = '{Pchar: c, Pn1: n1, Pn2: n2};
    commandReady = 1'b1;
    @(negedge clk);
    commandReady = 1'b0;
  endtask

  task automatic send(input CommandsType t, input logic [7:0] c, input logic [7:0] n1,
                      input logic [7:0] n2);
    put(t, c, n1, n2);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!busy) quiet++; else quiet = 0;
    end
    if (quiet < 3) begin
      total++;
      $display("FAIL timeout_%s: busy still %0b after %0d cycles, required 0", name, busy, n);
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL writes_missing_%s: got %0d pending writes, required 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    commandReady = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || top_line !== 5'd0)
      $display("FAIL reset_cursor: got (%0d,%0d) top %0d, required (0,0) top 0", cursor_row, cursor_col, top_line);
    else passed++;
    total++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_flags: got we %b busy %b ovf %b, required 0 0 0", ram_we, busy, overflow);
    else passed++;
  endtask

  task automatic test_input();
    do_reset();
    expect_write(5'd0, 7'd0, 8'h41);
    commandType  = INPUT;
    param        = '{Pchar: 8'h41, Pn1: 8'd0, Pn2: 8'd0};
    commandReady = 1'b1;
    @(negedge clk);
    commandReady = 1'b0;
    total++;
    if (ram_we !== 1'b0) $display("FAIL latency_early: got ram_we %b, required 0", ram_we);
    else passed++;
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1) $display("FAIL latency_write: got ram_we %b, required 1", ram_we);
    else passed++;
    wait_idle("input_a");
    total++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd1)
      $display("FAIL input_cursor: got (%0d,%0d), required (0,1)", cursor_row, cursor_col);
    else passed++;

    send(INPUT, 8'h08, 8'd0, 8'd0);
    expect_write(5'd0, 7'd0, 8'h42);
    send(INPUT, 8'h42, 8'd0, 8'd0);
    send(INPUT, 8'h0D, 8'd0, 8'd0);
    send(INPUT, 8'h0A, 8'd0, 8'd0);
    send(INPUT, 8'h07, 8'd0, 8'd0);
    wait_idle("ctrl");
    total++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0)
      $display("FAIL ctrl_cursor: got (%0d,%0d), required (1,0)", cursor_row, cursor_col);
    else passed++;
    expect_write(5'd1, 7'd0, 8'h43);
    send(INPUT, 8'h43, 8'd0, 8'd0);
    wait_idle("input_c");
  endtask

  task automatic test_cursor();
    do_reset();
    send(CUP, 8'd0, 8'd5, 8'd10);
    wait_idle("cup_5_10");
    total++;
    if (cursor_row !== 5'd4 || cursor_col !== 7'd9)
      $display("FAIL cup_5_10: got (%0d,%0d), required (4,9)", cursor_row, cursor_col);
    else passed++;
    send(CUP, 8'd0, 8'd99, 8'd200);
    wait_idle("cup_clamp");
    total++;
    if (cursor_row !== 5'd23 || cursor_col !== 7'd79)
      $display("FAIL cup_clamp: got (%0d,%0d), required (23,79)", cursor_row, cursor_col);
    else passed++;
    send(CUU, 8'd0, 8'd0, 8'd0);
    wait_idle("cuu_zero");
    total++;
    if (cursor_row !== 5'd22 || cursor_col !== 7'd79)
      $display("FAIL cuu_zero: got (%0d,%0d), required (22,79)", cursor_row, cursor_col);
    else passed++;
    send(CUD, 8'd0, 8'd5, 8'd0);
    send(CUB, 8'd0, 8'd100, 8'd0);
    send(CUF, 8'd0, 8'd0, 8'd0);
    wait_idle("cud_cub_cuf");
    total++;
    if (cursor_row !== 5'd23 || cursor_col !== 7'd1)
      $display("FAIL cud_cub_cuf: got (%0d,%0d), required (23,1)", cursor_row, cursor_col);
    else passed++;
    send(CUP, 8'd0, 8'd0, 8'd0);
    send(CUU, 8'd0, 8'd3, 8'd0);
    send(CUF, 8'd0, 8'd250, 8'd0);
    wait_idle("cup_zero");
    total++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd79 || top_line !== 5'd0)
      $display("FAIL cup_zero_cuf: got (%0d,%0d) top %0d, required (0,79) top 0", cursor_row, cursor_col, top_line);
    else passed++;
  endtask

  task automatic test_wrap_scroll();
    do_reset();
    send(CUP, 8'd0, 8'd24, 8'd1);
    for (int i = 0; i < 80; i++) begin
      expect_write(5'd23, 7'(i), 8'h78);
      send(INPUT, 8'h78, 8'd0, 8'd0);
    end
    wait_idle("x_line");
    total++;
    if (cursor_row !== 5'd23 || cursor_col !== 7'd79 || top_line !== 5'd0)
      $display("FAIL x_line_cursor: got (%0d,%0d) top %0d, required (23,79) top 0", cursor_row, cursor_col, top_line);
    else passed++;
    for (int i = 0; i < 80; i++) expect_write(5'd0, 7'(i), 8'h20);
    expect_write(5'd0, 7'd0, 8'h79);
    send(INPUT, 8'h79, 8'd0, 8'd0);
    wait_idle("wrap_y");
    total++;
    if (cursor_row !== 5'd23 || cursor_col !== 7'd1 || top_line !== 5'd1)
      $display("FAIL wrap_scroll: got (%0d,%0d) top %0d, required (23,1) top 1", cursor_row, cursor_col, top_line);
    else passed++;
    expect_write(5'd0, 7'd1, 8'h7A);
    send(INPUT, 8'h7A, 8'd0, 8'd0);
    for (int i = 0; i < 80; i++) expect_write(5'd1, 7'(i), 8'h20);
    send(NEL, 8'd0, 8'd0, 8'd0);
    wait_idle("nel_scroll");
    total++;
    if (cursor_row !== 5'd23 || cursor_col !== 7'd0 || top_line !== 5'd2)
      $display("FAIL nel_scroll: got (%0d,%0d) top %0d, required (23,0) top 2", cursor_row, cursor_col, top_line);
    else passed++;
  endtask

  task automatic test_ri_scroll();
    do_reset();
    for (int i = 0; i < 80; i++) expect_write(5'd23, 7'(i), 8'h20);
    send(RI, 8'd0, 8'd0, 8'd0);
    wait_idle("ri");
    total++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || top_line !== 5'd23)
      $display("FAIL ri_scroll: got (%0d,%0d) top %0d, required (0,0) top 23", cursor_row, cursor_col, top_line);
    else passed++;
    expect_write(5'd23, 7'd0, 8'h71);
    send(INPUT, 8'h71, 8'd0, 8'd0);
    wait_idle("ri_write");
  endtask

  task automatic test_overflow();
    do_reset();
    send(CUP, 8'd0, 8'd24, 8'd1);
    wait_idle("ovf_setup");
    for (int i = 0; i < 80; i++) expect_write(5'd0, 7'(i), 8'h20);
    for (int i = 0; i < 4; i++) expect_write(5'd0, 7'(i), 8'(8'h61 + i));
    put(IND, 8'd0, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1 || ram_we !== 1'b1 || overflow !== 1'b0)
      $display("FAIL in_clear: got busy %b we %b ovf %b, required 1 1 0", busy, ram_we, overflow);
    else passed++;
    for (int i = 0; i < 5; i++) put(INPUT, 8'(8'h61 + i), 8'd0, 8'd0);
    total++;
    if (overflow !== 1'b1) $display("FAIL overflow_set: got %b, required 1", overflow);
    else passed++;
    wait_idle("ovf_drain");
    total++;
    if (cursor_row !== 5'd23 || cursor_col !== 7'd4 || top_line !== 5'd1 || overflow !== 1'b1)
      $display("FAIL ovf_drain: got (%0d,%0d) top %0d ovf %b, required (23,4) top 1 ovf 1",
               cursor_row, cursor_col, top_line, overflow);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) expect_write(5'd0, 7'(i), 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) put(INPUT, 8'(8'h30 + i), 8'd0, 8'd0);
    wait_idle("b2b");
    total++;
    if (cursor_col !== 7'd3 || overflow !== 1'b0)
      $display("FAIL b2b: got col %0d ovf %b, required col 3 ovf 0", cursor_col, overflow);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    sb_en = 1'b0;
    send(RI, 8'd0, 8'd0, 8'd0);
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b1 || ram_we !== 1'b1)
      $display("FAIL mid_clear: got busy %b we %b, required 1 1", busy, ram_we);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || top_line !== 5'd0)
      $display("FAIL abort_clear: got busy %b we %b top %0d, required 0 0 0", busy, ram_we, top_line);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_input();
    test_cursor();
    test_wrap_scroll();
    test_ri_scroll();
    test_overflow();
    test_back_to_back();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
